led_flow_ctrl: RTL and testbench

Parametrised running-LED pattern generator for N board LEDs. Contains a base prescaler, a run-time speed divider, and four selectable patterns: shift-left, shift-right, ping-pong and fill-bar. Supports pause and configurable output polarity. Drives LED pins directly from registered outputs.

---
 rtl/led_flow_ctrl.sv | 135 +++++++++++++
 tb/tb_led_flow_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/led_flow_ctrl.sv
// Running-LED pattern generator: base prescaler, run-time speed divider and
// four patterns (shift-left, shift-right, ping-pong, fill-bar) with pause.
module led_flow_ctrl #(
  parameter int unsigned LED_NUM    = 8,
  parameter int unsigned TICK_MAX   = 24_999_999,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  input  logic               pause,
  output logic [LED_NUM-1:0] led,
  output logic               step,
  output logic [4:0]         pos
);

  localparam int unsigned        TW       = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam logic [TW-1:0]      TICK_TOP = TW'(TICK_MAX);
  localparam logic [4:0]         POS_MAX  = 5'(LED_NUM - 1);
  localparam logic [LED_NUM-1:0] LED_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [TW-1:0]      r_tick_cnt;
  logic [2:0]         r_div_cnt;
  logic [4:0]         r_pos;
  dir_t               r_dir;
  logic               r_step;
  logic [1:0]         r_mode_q;
  logic [LED_NUM-1:0] r_led;

  logic [TW-1:0]      w_tick_nxt;
  logic [2:0]         w_div_nxt;
  logic [4:0]         w_pos_nxt;
  dir_t               w_dir_nxt;
  logic               w_step_nxt;
  logic               w_tick;
  logic [2:0]         w_div_lim;
  logic [LED_NUM-1:0] w_pat;

  always_comb begin
    w_div_lim = 3'd0;
    case (speed)
      2'd0: w_div_lim = 3'd0;
      2'd1: w_div_lim = 3'd1;
      2'd2: w_div_lim = 3'd3;
      2'd3: w_div_lim = 3'd7;
      default: w_div_lim = 3'd0;
    endcase
  end

  assign w_tick = !pause && (r_tick_cnt == TICK_TOP);

  // Mode change wins over pause and over a step landing on the same edge.
  always_comb begin
    w_tick_nxt = r_tick_cnt;
    w_div_nxt  = r_div_cnt;
    w_pos_nxt  = r_pos;
    w_dir_nxt  = r_dir;
    w_step_nxt = 1'b0;
    if (mode != r_mode_q) begin
      w_tick_nxt = '0;
      w_div_nxt  = '0;
      w_pos_nxt  = '0;
      w_dir_nxt  = DIR_UP;
    end else if (!pause) begin
      w_tick_nxt = w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick) begin
        // >= lets a lowered speed take effect on the very next tick
        if (r_div_cnt >= w_div_lim) begin
          w_div_nxt  = '0;
          w_step_nxt = 1'b1;
          if (r_mode_q == 2'd2) begin
            if (r_dir == DIR_UP) begin
              if (r_pos == POS_MAX) begin
                w_dir_nxt = DIR_DOWN;
                w_pos_nxt = POS_MAX - 5'd1;
              end else begin
                w_pos_nxt = r_pos + 5'd1;
              end
            end else begin
              if (r_pos == 5'd0) begin
                w_dir_nxt = DIR_UP;
                w_pos_nxt = 5'd1;
              end else begin
                w_pos_nxt = r_pos - 5'd1;
              end
            end
          end else begin
            w_pos_nxt = (r_pos == POS_MAX) ? 5'd0 : r_pos + 5'd1;
          end
        end else begin
          w_div_nxt = r_div_cnt + 3'd1;
        end
      end
    end
  end

  always_comb begin
    w_pat = '0;
    for (int unsigned i = 0; i < LED_NUM; i++) begin
      case (r_mode_q)
        2'd1:    w_pat[i] = ((i + 32'(r_pos)) == (LED_NUM - 1));
        2'd3:    w_pat[i] = (i <= 32'(r_pos));
        default: w_pat[i] = (i == 32'(r_pos));
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tick_cnt <= '0;
      r_div_cnt  <= '0;
      r_pos      <= '0;
      r_dir      <= DIR_UP;
      r_step     <= 1'b0;
      r_mode_q   <= mode;
      r_led      <= LED_OFF;
    end else begin
      r_tick_cnt <= w_tick_nxt;
      r_div_cnt  <= w_div_nxt;
      r_pos      <= w_pos_nxt;
      r_dir      <= w_dir_nxt;
      r_step     <= w_step_nxt;
      r_mode_q   <= mode;
      r_led      <= (ACTIVE_LOW != 0) ? ~w_pat : w_pat;
    end
  end

  assign led  = r_led;
  assign step = r_step;
  assign pos  = r_pos;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl with LED_NUM=4, TICK_MAX=3, ACTIVE_LOW=1.
module tb_led_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       pause;
  logic [3:0] led;
  logic       step;
  logic [4:0] pos;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_flow_ctrl #(
    .LED_NUM(4),
    .TICK_MAX(3),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .speed(speed),
    .pause(pause),
    .led(led),
    .step(step),
    .pos(pos)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for the step pulse; checks gap in clocks and the new pos.
  task automatic expect_step(input string tag, input int exp_gap, input int exp_pos);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < exp_gap + 8);
    check_eq({tag, "_gap"}, n, exp_gap);
    check_eq({tag, "_pulse"}, {31'd0, step}, 32'd1);
    check_eq({tag, "_pos"}, {27'd0, pos}, exp_pos);
  endtask

  task automatic expect_led(input string tag, input logic [3:0] exp_led);
    @(negedge clk);
    check_eq({tag, "_led"}, {28'd0, led}, {28'd0, exp_led});
    check_eq({tag, "_nostep"}, {31'd0, step}, 32'd0);
  endtask

  initial begin
    logic [3:0] held_led;
    int pp_seq [6];
    pp_seq = '{2, 3, 2, 1, 0, 1};

    rst = 1'b0; mode = 2'd0; speed = 2'd0; pause = 1'b0;

    // 1: reset, shift-left
    cycles(3);
    check_eq("rst_led", {28'd0, led}, 32'hF);
    check_eq("rst_pos", {27'd0, pos}, 32'd0);
    check_eq("rst_step", {31'd0, step}, 32'd0);
    rst = 1'b1;
    cycles(1);
    check_eq("rel_led", {28'd0, led}, 32'hE);
    for (int k = 1; k <= 4; k++) begin
      expect_step("sl", 3, k % 4);
      expect_led("sl", ~(4'b0001 << (k % 4)));
    end

    // 2: ping-pong
    mode = 2'd2;
    cycles(1);
    check_eq("pp_start_pos", {27'd0, pos}, 32'd0);
    check_eq("pp_start_step", {31'd0, step}, 32'd0);
    expect_step("pp1", 4, 1);
    expect_led("pp1", 4'b1101);
    for (int k = 0; k < 6; k++) begin
      expect_step("pp", 3, pp_seq[k]);
      expect_led("pp", ~(4'b0001 << pp_seq[k]));
    end

    // 3: fill-bar
    mode = 2'd3;
    cycles(1);
    check_eq("fb_start_pos", {27'd0, pos}, 32'd0);
    expect_led("fb0", 4'b1110);
    expect_step("fb1", 3, 1); expect_led("fb1", 4'b1100);
    expect_step("fb2", 3, 2); expect_led("fb2", 4'b1000);
    expect_step("fb3", 3, 3); expect_led("fb3", 4'b0000);
    expect_step("fb4", 3, 0); expect_led("fb4", 4'b1110);

    // 4: speed=2 gives 16-clock steps; dropping to 0 with div_cnt=2 fires next tick
    speed = 2'd2;
    expect_step("sp2a", 15, 1); expect_led("sp2a", 4'b1100);
    expect_step("sp2b", 15, 2); expect_led("sp2b", 4'b1000);
    cycles(8);
    speed = 2'd0;
    expect_step("sp0a", 3, 3); expect_led("sp0a", 4'b0000);
    expect_step("sp0b", 3, 0); expect_led("sp0b", 4'b1110);

    // 5: pause with tick_cnt=1; resumes 2 -> 3 -> step
    pause = 1'b1;
    held_led = led;
    for (int k = 0; k < 20; k++) begin
      cycles(1);
      check_eq("pause_step", {31'd0, step}, 32'd0);
      check_eq("pause_led", {28'd0, led}, {28'd0, held_led});
      check_eq("pause_pos", {27'd0, pos}, 32'd0);
    end
    pause = 1'b0;
    expect_step("resume", 3, 1);
    expect_led("resume", 4'b1100);

    // 6a: mode 0->1 at pos=2, landing on a would-be step edge
    mode = 2'd0;
    cycles(1);
    check_eq("m0_pos", {27'd0, pos}, 32'd0);
    expect_step("m0a", 4, 1); expect_led("m0a", 4'b1101);
    expect_step("m0b", 3, 2);
    cycles(3);
    mode = 2'd1;
    cycles(1);
    check_eq("mchg_pos", {27'd0, pos}, 32'd0);
    check_eq("mchg_step", {31'd0, step}, 32'd0);
    expect_led("mchg", 4'b0111);

    // 6b: reset mid-run
    cycles(5);
    rst = 1'b0;
    cycles(1);
    check_eq("mrst_led", {28'd0, led}, 32'hF);
    check_eq("mrst_pos", {27'd0, pos}, 32'd0);
    check_eq("mrst_step", {31'd0, step}, 32'd0);
    rst = 1'b1;
    cycles(1);
    check_eq("mrel_led", {28'd0, led}, 32'h7);
    expect_step("sr1", 3, 1);
    expect_led("sr1", 4'b1011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
